// File: rtl/store_buffer_param_pkg.sv
// Shared word/byte geometry and drain-handshake state for the store buffer.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package store_buffer_param_pkg;

    localparam int WORD_SIZE  = `WORD_SIZE;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_WAIT = 1'b1
    } drain_state_e;

endpackage

// File: rtl/store_buffer_param_forward.sv
// Load-forwarding search over buffered stores, youngest match wins.
// Entries arrive in age order: index 0 is the oldest.
module sb_forward_match
    import store_buffer_param_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DWIDTH = WORD_SIZE,
    parameter int AWIDTH = WORD_SIZE
) (
    input  logic [DEPTH-1:0]             valid_i,
    input  logic [DEPTH-1:0][AWIDTH-1:0] addr_i,
    input  logic [DEPTH-1:0][DWIDTH-1:0] data_i,
    input  logic [DEPTH-1:0]             byte_i,
    input  logic                         ld_valid,
    input  logic [AWIDTH-1:0]            ld_addr,
    input  logic                         ld_byte,
    output logic                         hit,
    output logic                         conflict,
    output logic [DWIDTH-1:0]            data
);

    logic                  found;
    logic [DWIDTH-1:0]     m_data;
    logic                  m_byte;
    logic [BYTE_OFF_W-1:0] m_off;
    logic [BYTE_OFF_W-1:0] ld_off;

    assign ld_off = ld_addr[BYTE_OFF_W-1:0];

    always_comb begin
        found  = 1'b0;
        m_data = '0;
        m_byte = 1'b0;
        m_off  = '0;
        // Later (younger) matches overwrite earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_i[i] && addr_i[i][AWIDTH-1:BYTE_OFF_W] == ld_addr[AWIDTH-1:BYTE_OFF_W]) begin
                found  = 1'b1;
                m_data = data_i[i];
                m_byte = byte_i[i];
                m_off  = addr_i[i][BYTE_OFF_W-1:0];
            end
        end
    end

    always_comb begin
        hit      = 1'b0;
        conflict = 1'b0;
        data     = '0;
        if (ld_valid && found) begin
            if (!m_byte) begin
                hit  = 1'b1;
                data = ld_byte ? DWIDTH'(m_data[{ld_off, 3'b000} +: 8]) : m_data;
            end else if (ld_byte && m_off == ld_off) begin
                hit  = 1'b1;
                data = DWIDTH'(m_data[7:0]);
            end else begin
                // Byte entry covers only part of what the load needs.
                conflict = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_buffer_param.sv
// Circular store buffer with lazy/eager drain to the dcache and load forwarding.
module store_buffer_param
    import store_buffer_param_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DWIDTH  = WORD_SIZE,
    parameter int AWIDTH  = WORD_SIZE,
    parameter int EAGER   = 1,
    parameter int HIGH_WM = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AWIDTH-1:0]          st_addr,
    input  logic [DWIDTH-1:0]          st_data,
    input  logic                       st_byte,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AWIDTH-1:0]          ld_addr,
    input  logic                       ld_byte,
    output logic                       ld_hit,
    output logic [DWIDTH-1:0]          ld_data,
    output logic                       ld_conflict,
    output logic                       mem_req,
    output logic [AWIDTH-1:0]          mem_addr,
    output logic [DWIDTH-1:0]          mem_data,
    output logic                       mem_byte,
    input  logic                       mem_ack,
    input  logic                       flush,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       sb_stall
);

    localparam int           PW        = $clog2(DEPTH);
    localparam int           CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] HIGH_WM_C = CW'(HIGH_WM);
    localparam logic         EAGER_C   = (EAGER != 0);

    logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d;
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][AWIDTH-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DWIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]             byte_q, byte_d;
    drain_state_e                 state_q, state_d;

    logic push, pop, drain_want;

    logic [DEPTH-1:0]             age_valid;
    logic [DEPTH-1:0][AWIDTH-1:0] age_addr;
    logic [DEPTH-1:0][DWIDTH-1:0] age_data;
    logic [DEPTH-1:0]             age_byte;

    always_comb begin
        st_ready   = (count_q != DEPTH_C);
        sb_empty   = (count_q == '0);
        push       = st_valid & st_ready;
        drain_want = EAGER_C | (count_q >= HIGH_WM_C) | flush | !ld_valid;
        // An outstanding request stays up until acked, whatever the load port does.
        mem_req    = (state_q == DRAIN_WAIT) | (!sb_empty & drain_want);
        pop        = mem_req & mem_ack;
        mem_addr   = mem_req ? addr_q[head_q] : '0;
        mem_data   = mem_req ? data_q[head_q] : '0;
        mem_byte   = mem_req ? byte_q[head_q] : 1'b0;
        state_d    = (mem_req && !mem_ack) ? DRAIN_WAIT : DRAIN_IDLE;
        sb_stall   = (st_valid & !st_ready) | ld_conflict;
        count      = count_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        byte_d  = byte_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = st_addr;
            data_d[tail_q]  = st_byte ? DWIDTH'(st_data[7:0]) : st_data;
            byte_d[tail_q]  = st_byte;
            tail_d          = tail_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            byte_q  <= '0;
            state_q <= DRAIN_IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            byte_q  <= byte_d;
            state_q <= state_d;
        end
    end

    // Rotate storage so the search sees entries oldest-first.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PW-1:0] slot;
            assign slot          = head_q + PW'(gi);
            assign age_valid[gi] = valid_q[slot];
            assign age_addr[gi]  = addr_q[slot];
            assign age_data[gi]  = data_q[slot];
            assign age_byte[gi]  = byte_q[slot];
        end
    endgenerate

    sb_forward_match #(
        .DEPTH (DEPTH),
        .DWIDTH(DWIDTH),
        .AWIDTH(AWIDTH)
    ) u_fwd (
        .valid_i (age_valid),
        .addr_i  (age_addr),
        .data_i  (age_data),
        .byte_i  (age_byte),
        .ld_valid(ld_valid),
        .ld_addr (ld_addr),
        .ld_byte (ld_byte),
        .hit     (ld_hit),
        .conflict(ld_conflict),
        .data    (ld_data)
    );

endmodule

// File: tb/tb_store_buffer_param.sv
// Directed bench for store_buffer_param with DEPTH=4 and lazy drain.
module tb_store_buffer_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid, st_byte, st_ready;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_byte, ld_hit, ld_conflict;
    logic [31:0] ld_addr, ld_data;
    logic        mem_req, mem_byte, mem_ack, flush;
    logic [31:0] mem_addr, mem_data;
    logic        sb_empty, sb_stall;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    logic [31:0] drain_exp [4] = '{32'h104, 32'h108, 32'h10C, 32'h500};

    always #5 clk = ~clk;

    store_buffer_param #(
        .DEPTH (4),
        .DWIDTH(32),
        .AWIDTH(32),
        .EAGER (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_byte    (st_byte),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_byte    (ld_byte),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .ld_conflict(ld_conflict),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_byte   (mem_byte),
        .mem_ack    (mem_ack),
        .flush      (flush),
        .sb_empty   (sb_empty),
        .count      (count),
        .sb_stall   (sb_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_byte = 1'b0; mem_ack = 1'b0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_empty", 32'(sb_empty), 32'd1);
        check("rst_ld_hit", 32'(ld_hit), 32'd0);
        check("rst_conflict", 32'(ld_conflict), 32'd0);
        check("rst_stall", 32'(sb_stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);

        // Fill to DEPTH while loads keep the lazy drain quiet; no acks.
        ld_valid = 1'b1; ld_addr = 32'h0; ld_byte = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h100 + 32'(4 * i); st_data = 32'(i + 1); st_byte = 1'b0;
            #1;
            check("fill_st_ready", 32'(st_ready), 32'd1);
            tick();
        end
        st_valid = 1'b0;
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_st_ready", 32'(st_ready), 32'd0);
        check("full_mem_req", 32'(mem_req), 32'd1);
        check("full_mem_addr", mem_addr, 32'h100);
        check("full_mem_data", mem_data, 32'h1);
        st_valid = 1'b1; st_addr = 32'h110; st_data = 32'h99;
        #1;
        check("full_stall", 32'(sb_stall), 32'd1);
        tick();
        st_valid = 1'b0; ld_addr = 32'h108;
        #1;
        check("full_count_after5", 32'(count), 32'd4);
        check("fwd_0x108", ld_data, 32'h3);

        // Ack with a concurrent store while full: only the pop happens.
        ld_addr = 32'h0;
        mem_ack = 1'b1; st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h55;
        #1;
        check("popfull_st_ready", 32'(st_ready), 32'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        check("popfull_count", 32'(count), 32'd3);
        check("popfull_st_ready2", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0; ld_addr = 32'h500;
        #1;
        check("refill_count", 32'(count), 32'd4);
        check("wrap_fwd_0x500", ld_data, 32'h55);
        check("wrap_mem_addr", mem_addr, 32'h104);

        ld_valid = 1'b0; mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_order", mem_addr, drain_exp[i]);
            tick();
        end
        mem_ack = 1'b0;
        #1;
        check("drained_empty", 32'(sb_empty), 32'd1);
        check("drained_mem_req", 32'(mem_req), 32'd0);

        // Word store then byte forward; new entry invisible in its own cycle.
        ld_valid = 1'b1; ld_addr = 32'h200; ld_byte = 1'b0;
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hAABBCCDD; st_byte = 1'b0;
        #1;
        check("same_cycle_hit", 32'(ld_hit), 32'd0);
        tick();
        st_valid = 1'b0; ld_addr = 32'h201; ld_byte = 1'b1;
        #1;
        check("byte_fwd_hit", 32'(ld_hit), 32'd1);
        check("byte_fwd_data", ld_data, 32'h000000CC);
        check("lazy_mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        check("stray_ack_count", 32'(count), 32'd1);
        ld_valid = 1'b0;
        #1;
        check("idle_ld_hit", 32'(ld_hit), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd1);
        tick();
        ld_valid = 1'b1;
        #1;
        check("held_mem_req", 32'(mem_req), 32'd1);
        check("held_mem_data", mem_data, 32'hAABBCCDD);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        check("held_pop_count", 32'(count), 32'd0);

        // Byte store: partial-coverage conflict until it drains.
        ld_addr = 32'h0; ld_byte = 1'b0;
        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'hFFFFFF11; st_byte = 1'b1;
        tick();
        st_valid = 1'b0; st_byte = 1'b0; ld_addr = 32'h300; ld_byte = 1'b0;
        #1;
        check("bconf_conflict", 32'(ld_conflict), 32'd1);
        check("bconf_hit", 32'(ld_hit), 32'd0);
        check("bconf_stall", 32'(sb_stall), 32'd1);
        ld_byte = 1'b1;
        #1;
        check("bsame_data", ld_data, 32'h11);
        check("bsame_hit", 32'(ld_hit), 32'd1);
        ld_addr = 32'h302;
        #1;
        check("bother_conflict", 32'(ld_conflict), 32'd1);
        ld_addr = 32'h300; ld_byte = 1'b0; flush = 1'b1;
        #1;
        check("flush_mem_req", 32'(mem_req), 32'd1);
        check("flush_mem_data", mem_data, 32'h11);
        check("flush_mem_byte", 32'(mem_byte), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; flush = 1'b0;
        #1;
        check("bconf_cleared", 32'(ld_conflict), 32'd0);
        check("bconf_empty", 32'(sb_empty), 32'd1);

        // Two stores to one word: youngest forwards.
        ld_addr = 32'h0;
        st_valid = 1'b1; st_addr = 32'h400; st_data = 32'h1; st_byte = 1'b0;
        tick();
        st_data = 32'h2;
        tick();
        st_valid = 1'b0; ld_addr = 32'h400;
        #1;
        check("youngest_data", ld_data, 32'h2);
        check("youngest_count", 32'(count), 32'd2);

        // Reset in the middle of a drain handshake.
        ld_valid = 1'b0;
        #1;
        check("mid_mem_req", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b0; mem_ack = 1'b1; st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h66;
        tick();
        rst = 1'b1; mem_ack = 1'b0; st_valid = 1'b0;
        #1;
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_mem_req", 32'(mem_req), 32'd0);
        check("mrst_empty", 32'(sb_empty), 32'd1);
        flush = 1'b1;
        #1;
        check("mrst_flush_req", 32'(mem_req), 32'd0);
        tick();
        flush = 1'b0; ld_valid = 1'b1; ld_addr = 32'h600;
        #1;
        check("mrst_flush_count", 32'(count), 32'd0);
        check("mrst_discard_hit", 32'(ld_hit), 32'd0);
        ld_addr = 32'h400;
        #1;
        check("mrst_old_hit", 32'(ld_hit), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
